// File: rtl/cache_mem_arbiter.sv
// Two-client (DC/IC) arbiter onto a single registered line-memory port with a sticky error flag.
// Define ARB_ROUND_ROBIN_EN to make DC/IC ties alternate instead of always favouring DC.
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dc_read,
  input  logic                  dc_write,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [LINE_WIDTH-1:0] dc_wdata,
  output logic [LINE_WIDTH-1:0] dc_rdata,
  output logic                  dc_resp,
  input  logic                  ic_read,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic [LINE_WIDTH-1:0] ic_rdata,
  output logic                  ic_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic                  error
);

  localparam int OFS_W = $clog2(LINE_WIDTH / 8);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]      TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit                    TMO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK  = ADDR_WIDTH'((64'd1 << OFS_W) - 64'd1);

  typedef enum logic [1:0] {IDLE, BUSY_DC, BUSY_IC, GAP} state_t;

  state_t                  state_q, state_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    error_q, error_d;
  logic                    last_ic_q, last_ic_d;
  logic [CNT_W-1:0]        tmo_cnt_q, tmo_cnt_d;

  logic dc_pend, ic_pend, dc_first;

  always_comb begin
    dc_pend = dc_read | dc_write;
    ic_pend = ic_read;
`ifdef ARB_ROUND_ROBIN_EN
    dc_first = last_ic_q;
`else
    dc_first = 1'b1;
`endif
  end

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    error_d     = error_q;
    last_ic_d   = last_ic_q;
    tmo_cnt_d   = tmo_cnt_q;

    case (state_q)
      IDLE: begin
        if (mem_resp) error_d = 1'b1;
        if (dc_pend && (dc_first || !ic_pend)) begin
          state_d     = BUSY_DC;
          // A read+write collision is issued as a read only.
          mem_read_d  = dc_read;
          mem_write_d = dc_write & ~dc_read;
          mem_addr_d  = dc_addr & ~OFS_MASK;
          mem_wdata_d = dc_wdata;
          if (dc_read && dc_write) error_d = 1'b1;
        end else if (ic_pend) begin
          state_d     = BUSY_IC;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = ic_addr & ~OFS_MASK;
          mem_wdata_d = '0;
        end
      end
      BUSY_DC, BUSY_IC: begin
        if (mem_resp) begin
          state_d     = GAP;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          last_ic_d   = (state_q == BUSY_IC);
          tmo_cnt_d   = '0;
        end else begin
          // Counter saturates at the limit; the transaction keeps waiting.
          if (tmo_cnt_q != TMO_LIMIT) tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (TMO_EN && (tmo_cnt_q + 1'b1 == TMO_LIMIT)) error_d = 1'b1;
        end
      end
      GAP: begin
        if (mem_resp) error_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      error_q     <= 1'b0;
      last_ic_q   <= 1'b1;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      error_q     <= error_d;
      last_ic_q   <= last_ic_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign error     = error_q;
  assign dc_resp   = (state_q == BUSY_DC) & mem_resp;
  assign ic_resp   = (state_q == BUSY_IC) & mem_resp;
  assign dc_rdata  = mem_rdata;
  assign ic_rdata  = mem_rdata;

endmodule
